// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU front end: IR field layout, opcodes and fetch states.
package vpu_pkg;
  localparam int OPER_MSB = 31;
  localparam int OPER_LSB = 27;
  localparam int RDST_MSB = 26;
  localparam int RDST_LSB = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 0;

  localparam logic [4:0] OPC_MOVSGPR = 5'd0;
  localparam logic [4:0] OPC_MOVDGPR = 5'd1;
  localparam logic [4:0] OPC_MOVS    = 5'd2;
  localparam logic [4:0] OPC_MOVD    = 5'd3;
  localparam logic [4:0] OPC_ADD     = 5'd4;
  localparam logic [4:0] OPC_SUB     = 5'd5;
  localparam logic [4:0] OPC_MUL     = 5'd6;
  localparam logic [4:0] OPC_ROR     = 5'd7;
  localparam logic [4:0] OPC_RAND    = 5'd8;
  localparam logic [4:0] OPC_RXOR    = 5'd9;
  localparam logic [4:0] OPC_RNOT    = 5'd10;
  localparam logic [4:0] OPC_HALT    = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALTED
  } fetch_state_t;
endpackage

// File: rtl/vpu_ir_fifo.sv
// DEPTH x W instruction buffer; write-after-push, head visible the cycle after push.
// Pop with an empty buffer is not allowed by the caller; head reads zero while empty.
module vpu_ir_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/vpu_ifetch.sv
// Sequential instruction fetch with one outstanding read, buffered IR issue, stop on HALT.
// First IR three cycles after start at memory latency 1; fetch pauses while the buffer is full.
module vpu_ifetch
  import vpu_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 2,
  parameter logic [4:0] OP_HALT = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  output logic [31:0]       ir_data,
  input  logic              ir_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              restart;
  logic              rsp;
  logic              is_halt;
  logic              push;
  logic              pop;

  assign restart = start && (state_q == ST_IDLE || state_q == ST_HALTED);
  // Responses outside WAIT are stale (pre-reset or pre-restart) and are dropped.
  assign rsp     = (state_q == ST_WAIT) && imem_rvalid;
  assign is_halt = (imem_rdata[OPER_MSB:OPER_LSB] == OP_HALT);
  assign push    = rsp && !is_halt && !fifo_full;
  assign pop     = ir_valid && ir_ready;

  assign imem_req  = (state_q == ST_REQ) && (fifo_count < CNT_W'(DEPTH));
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir_valid  = !fifo_empty;
  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT) || !fifo_empty;
  assign done      = (state_q == ST_HALTED) && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc_q    <= start_pc;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_req) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (is_halt) begin
              state_q <= ST_HALTED;
            end else begin
              pc_q    <= pc_q + ADDR_W'(1);
              state_q <= ST_REQ;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  vpu_ir_fifo #(
    .DEPTH(DEPTH),
    .W    (32)
  ) u_ir_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (restart),
    .push     (push),
    .push_data(imem_rdata),
    .pop      (pop),
    .head     (ir_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
endmodule

// File: tb/tb_vpu_ifetch.sv
// Bench for vpu_ifetch: memory responder, program-walk reference model and per-cycle compare.
module tb_vpu_ifetch;
  localparam logic [31:0] HALT_W = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic        ir_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [7:0]  pc;

  logic [31:0] mem [256];
  logic        mem_rv = 1'b0;
  logic [31:0] mem_dat = 32'h0;
  logic        stale_rv = 1'b0;
  logic [31:0] stale_dat = 32'h0;
  logic        outstanding = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  int          lat_cnt = 0;
  int          lat_max = 1;
  int          req_cnt = 0;

  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] got_q[$];

  int checks = 0;
  int errors = 0;

  assign imem_rvalid = mem_rv | stale_rv;
  assign imem_rdata  = stale_rv ? stale_dat : mem_dat;

  always #5 clk = ~clk;

  vpu_ifetch #(.ADDR_W(8), .DEPTH(2), .OP_HALT(5'b11111)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_data(ir_data),
    .ir_ready(ir_ready), .busy(busy), .done(done), .pc(pc)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: fetch walks memory from pc until a HALT word; that address is fetched but not issued.
  task automatic load_program(input logic [7:0] first);
    logic [7:0] a;
    a = first;
    for (int i = 0; i < 256; i++) begin
      exp_addr_q.push_back(a);
      if (mem[a][31:27] == 5'b11111) break;
      exp_data_q.push_back(mem[a]);
      a = a + 8'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] first);
    load_program(first);
    start_pc = first;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!(done && exp_data_q.size() == 0 && exp_addr_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail({name, " timeout"});
    check({name, " done"}, {31'b0, done}, 32'd1);
  endtask

  // Memory responder and per-cycle compare, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_rv = 1'b0;
      outstanding = 1'b0;
    end else begin
      if (mem_rv) begin
        mem_rv = 1'b0;
        outstanding = 1'b0;
      end
      if (outstanding) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_rv = 1'b1;
          mem_dat = mem[req_addr];
        end
      end
      if (ir_valid && ir_ready) begin
        if (exp_data_q.size() == 0) fail("issue with empty model stream");
        else check("issued word", ir_data, exp_data_q.pop_front());
        got_q.push_back(ir_data);
      end
      if (imem_req) begin
        check("single outstanding", {31'b0, outstanding}, 32'd0);
        if (exp_addr_q.size() == 0) fail("unexpected imem_req");
        else check("imem_addr", {24'b0, imem_addr}, {24'b0, exp_addr_q.pop_front()});
        req_cnt++;
        outstanding = 1'b1;
        lat_cnt = $urandom_range(1, lat_max);
        req_addr = imem_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    int base;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = {5'd4, 3'd0, 8'(i), 16'h00AB};
    mem[8'h10] = 32'h20C4_0001;
    mem[8'h11] = 32'h2908_8002;
    mem[8'h12] = 32'h5000_0003;
    mem[8'h13] = HALT_W;
    mem[8'h26] = HALT_W;
    mem[8'h02] = HALT_W;
    mem[8'h8A] = HALT_W;
    mem[8'h34] = HALT_W;
    mem[8'h42] = HALT_W;

    repeat (2) @(negedge clk);
    check("rst imem_req", {31'b0, imem_req}, 32'd0);
    check("rst imem_addr", {24'b0, imem_addr}, 32'd0);
    check("rst ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst ir_data", ir_data, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst pc", {24'b0, pc}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Short program ending in HALT at 0x13, latency 1, always ready.
    got_q.delete();
    do_start(8'h10);
    first_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) check("t1 req at T+1", {31'b0, imem_req}, 32'd1);
      if (ir_valid && first_k == 0) first_k = k;
    end
    check("t1 first ir_valid cycle", first_k, 32'd3);
    wait_done(100, "t1");
    check("t1 issued count", got_q.size(), 32'd3);
    check("t1 word0", got_q[0], 32'h20C4_0001);
    check("t1 word2", got_q[2], 32'h5000_0003);
    check("t1 pc", {24'b0, pc}, 32'h13);
    repeat (4) tick();
    check("t1 busy after done", {31'b0, busy}, 32'd0);

    // Backpressure: buffer fills after exactly two fetches.
    ir_ready = 1'b0;
    base = req_cnt;
    do_start(8'h20);
    repeat (5) tick();
    check("t2 head early", ir_data, 32'h2020_00AB);
    repeat (15) tick();
    check("t2 req count", req_cnt - base, 32'd2);
    check("t2 imem_req low", {31'b0, imem_req}, 32'd0);
    check("t2 ir_valid", {31'b0, ir_valid}, 32'd1);
    check("t2 head stable", ir_data, 32'h2020_00AB);
    check("t2 busy", {31'b0, busy}, 32'd1);
    ir_ready = 1'b1;
    wait_done(200, "t2");

    // PC wrap across 0xFF.
    base = req_cnt;
    do_start(8'hFE);
    wait_done(100, "t3");
    check("t3 pc", {24'b0, pc}, 32'h02);
    check("t3 req count", req_cnt - base, 32'd5);

    // Variable latency with random ready.
    lat_max = 5;
    do_start(8'h80);
    n = 0;
    while (!(done && exp_data_q.size() == 0 && exp_addr_q.size() == 0) && n < 3000) begin
      ir_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ir_ready = 1'b1;
    lat_max = 1;
    wait_done(50, "t4");

    // Reset while a read is outstanding, then a stale response in IDLE.
    do_start(8'h60);
    n = 0;
    while (!(outstanding && !mem_rv) && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) fail("t5 no outstanding read");
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    check("t5 imem_req", {31'b0, imem_req}, 32'd0);
    check("t5 ir_valid", {31'b0, ir_valid}, 32'd0);
    check("t5 ir_data", ir_data, 32'd0);
    check("t5 busy", {31'b0, busy}, 32'd0);
    check("t5 pc", {24'b0, pc}, 32'd0);
    tick();
    rst_n = 1'b1;
    stale_dat = 32'hDEAD_BEEF;
    stale_rv = 1'b1;
    tick();
    stale_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5 stale not buffered", {31'b0, ir_valid}, 32'd0);
      check("t5 idle busy", {31'b0, busy}, 32'd0);
      check("t5 idle done", {31'b0, done}, 32'd0);
    end

    // start during WAIT is ignored; start from HALTED restarts at the new pc.
    do_start(8'h30);
    tick();
    start_pc = 8'h70;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, "t6a");
    check("t6 pc", {24'b0, pc}, 32'h34);
    do_start(8'h40);
    check("t6 restart done", {31'b0, done}, 32'd0);
    check("t6 restart busy", {31'b0, busy}, 32'd1);
    check("t6 restart addr", {24'b0, imem_addr}, 32'h40);
    check("t6 restart req", {31'b0, imem_req}, 32'd1);
    wait_done(100, "t6b");
    check("t6 pc after", {24'b0, pc}, 32'h42);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vpu_ifetch.md
Name: vpu_ifetch

Overview:
Instruction fetch/issue front end that produces the 32-bit IR stream consumed by the VPU execute datapath. On start it fetches sequential words from instruction memory over a single-outstanding req/rvalid port and buffers them in a small FIFO. It presents them to the execute stage over a valid/ready handshake. Fetch stops at a HALT opcode, which is consumed and never issued.

Parameters:
ADDR_W, 8, instruction memory word-address width; PC wraps modulo 2^ADDR_W
DEPTH, 2, IR buffer entries (power of 2, >=2)
OP_HALT, 5'b11111, opcode in IR[31:27] that terminates fetch

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  pulse: begin fetching at start_pc (honoured only in IDLE or HALTED)
start_pc  in  ADDR_W  first fetch address
imem_req  out  1  read request, one cycle per fetch
imem_addr  out  ADDR_W  word address, valid with imem_req
imem_rvalid  in  1  read data valid; >=1 cycle after imem_req
imem_rdata  in  32  instruction word
ir_valid  out  1  buffer head holds an instruction
ir_data  out  32  head instruction (IR format: oper[31:27] rdst[26:22] rsrc1[21:17] imm_mode[16] rsrc2/isrc[15:0])
ir_ready  in  1  execute stage accepts; transfer when ir_valid && ir_ready
busy  out  1  state != IDLE/HALTED, or buffer non-empty
done  out  1  state HALTED and buffer empty
pc  out  ADDR_W  address of next fetch

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, buffer empty; imem_req=0, imem_addr=0, ir_valid=0, ir_data=0, busy=0, done=0.
- States: IDLE, REQ, WAIT, HALTED.
- IDLE/HALTED: start=1 -> pc<=start_pc, buffer cleared, state REQ. start in REQ/WAIT ignored.
- REQ: imem_req = (count < DEPTH), combinational from registered state/count; imem_addr=pc. On req, next state WAIT; otherwise stay in REQ.
- WAIT: await imem_rvalid. On rvalid: if imem_rdata[31:27]==OP_HALT -> state HALTED, word discarded, pc unchanged; else push word, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), state REQ.
- Max one outstanding read; rvalid outside WAIT is ignored (covers stale data after reset or restart).
- Space check in REQ only (count<DEPTH); with one outstanding, a WAIT push always has room. Pop in the push cycle is legal; count is unchanged.
- Issue: ir_valid = !empty; ir_data = head; pop on ir_valid && ir_ready. FIFO order preserved; no bypass.
- Latency, mem latency 1, ready=1: start@T -> imem_req@T+1 -> rvalid@T+2 -> ir_valid@T+3. Steady state: one instruction per 2 cycles.
- HALTED: no requests. Buffered words continue to drain. done=1 once empty and stays until start or reset.
- Reset mid-operation: outstanding read abandoned, buffer contents lost.

Decomposition:
- vpu_pkg: opcode localparams (MOVSGPR..RNOT, OP_HALT), IR field bit positions, state enum type.
- Sub-module vpu_ir_fifo: DEPTH x 32 synchronous FIFO with push/pop/count/empty/full and the same clk/rst_n.

Test Plan:
- start_pc=0x10, mem returns 3 ALU words then HALT at 0x13, latency 1, ir_ready=1 -> imem_addr 0x10..0x13, 3 words issued in order, first ir_valid at T+3, done=1 after the third pop, no req after 0x13.
- ir_ready=0 for 20 cycles -> exactly DEPTH=2 requests, imem_req held low, ir_valid=1 with first word stable; ready=1 -> words drain in order and fetch resumes.
- start_pc=0xFE, 4 non-halt words -> addresses 0xFE,0xFF,0x00,0x01; pc wraps.
- Variable latency 1..5 cycles with random ready -> never >1 outstanding; issued stream equals memory contents in order.
- Assert rst_n=0 during WAIT, then pulse rvalid with 0xDEADBEEF while in IDLE -> outputs at reset values, word not buffered, ir_valid stays 0.
- start pulsed during WAIT -> ignored, pc continues; start in HALTED with start_pc=0x40 -> done=0, busy=1, imem_addr=0x40 next cycle.
